// File: rtl/pixel_integrator_pkg.sv
// rtl/pixel_integrator_pkg.sv - mode encodings and clamp helpers for the pixel integrator
package pixel_integrator_pkg;

  localparam logic [1:0] MODE_FREE   = 2'b00;
  localparam logic [1:0] MODE_LINE   = 2'b01;
  localparam logic [1:0] MODE_FREEZE = 2'b10;

  // Midscale value 2^(w-1) of a w-bit accumulator
  function automatic logic [31:0] midscale(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

  // Largest value a w-bit accumulator can hold
  function automatic logic [32:0] full_scale(input int unsigned w);
    return (33'd1 << w) - 33'd1;
  endfunction

  // acc +/- mag, clamped to [0, 2^w-1]; the extra top bit catches overflow
  function automatic logic [31:0] sat_add(input logic [31:0] acc, input logic [31:0] mag,
                                          input logic up, input int unsigned w);
    logic [32:0] sum;
    if (up) begin
      sum = {1'b0, acc} + {1'b0, mag};
      if (sum > full_scale(w)) sum = full_scale(w);
    end else if (mag > acc) begin
      sum = '0;
    end else begin
      sum = {1'b0, acc - mag};
    end
    return sum[31:0];
  endfunction

  // True when acc +/- mag lies outside [0, 2^w-1] and had to be clamped
  function automatic logic sat_hit(input logic [31:0] acc, input logic [31:0] mag,
                                   input logic up, input int unsigned w);
    if (up) return ({1'b0, acc} + {1'b0, mag}) > full_scale(w);
    return mag > acc;
  endfunction

endpackage

// File: rtl/pixel_integrator_chan.sv
// rtl/pixel_integrator_chan.sv - one synchronised saturating accumulator channel
module pixel_integrator_chan
  import pixel_integrator_pkg::*;
#(
  parameter int ACC_W       = 5,
  parameter int SYNC_STAGES = 2,
  parameter int STEP_W      = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              comp_i,
  input  logic              vis_d_i,
  input  logic              ls_d_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic [1:0]        mode_i,
  output logic [ACC_W-1:0]  acc_o,
  output logic              sat_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic                   s_bit;
  logic                   load;
  logic                   step_en;

  assign s_bit   = sync_q[SYNC_STAGES-1];
  assign load    = ls_d_i && (mode_i == MODE_LINE);
  assign step_en = vis_d_i && (mode_i != MODE_FREEZE) && !load;
  assign acc_o   = acc_q;

  // Metastability chain on the asynchronous comparator bit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= comp_i;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Line restart beats freeze, freeze beats integration
  always_comb begin
    acc_d = acc_q;
    if (load)
      acc_d = ACC_W'(midscale(ACC_W));
    else if (step_en)
      acc_d = ACC_W'(sat_add(32'(acc_q), 32'(step_i), s_bit, ACC_W));
  end

  // Accumulator register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

`ifdef PIXEL_INTEGRATOR_SAT_STATS_EN
  logic sat_q, sat_d;

  // Sticky clamp flag; a delayed line start clears it even if a clamp happens too
  always_comb begin
    sat_d = sat_q;
    if (ls_d_i)
      sat_d = 1'b0;
    else if (step_en && sat_hit(32'(acc_q), 32'(step_i), s_bit, ACC_W))
      sat_d = 1'b1;
  end

  // Saturation flag register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sat_q <= 1'b0;
    else       sat_q <= sat_d;
  end

  assign sat_o = sat_q;
`else
  assign sat_o = 1'b0;
`endif

endmodule

// File: rtl/pixel_integrator.sv
// rtl/pixel_integrator.sv - comparator-stream pixel integrator top (option macro PIXEL_INTEGRATOR_SAT_STATS_EN)
module pixel_integrator
  import pixel_integrator_pkg::*;
#(
  parameter int CHANNELS    = 3,
  parameter int ACC_W       = 5,
  parameter int OUT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int STEP_W      = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       comp_in,
  input  logic                      visible,
  input  logic                      line_start,
  input  logic [STEP_W-1:0]         step,
  input  logic [1:0]                mode,
  input  logic [1:0]                gain,
  output logic [CHANNELS*OUT_W-1:0] pix_out,
  output logic                      pix_valid,
  output logic [CHANNELS*ACC_W-1:0] acc_out,
  output logic [CHANNELS-1:0]       sat_flag
);

  localparam logic [31:0] OUT_MAX = (32'd1 << OUT_W) - 32'd1;

  logic [SYNC_STAGES-1:0]    vis_q, ls_q;
  logic                      vis_d, ls_d;
  logic [CHANNELS*OUT_W-1:0] pix_q, pix_d;
  logic                      pix_valid_q;

  assign vis_d     = vis_q[SYNC_STAGES-1];
  assign ls_d      = ls_q[SYNC_STAGES-1];
  assign pix_out   = pix_q;
  assign pix_valid = pix_valid_q;

  // Accumulator scaled by 2^g in ACC_W+3 bits, then clamped to the output range
  function automatic logic [OUT_W-1:0] scale_out(input logic [ACC_W-1:0] a, input logic [1:0] g);
    logic [ACC_W+2:0] sc;
    sc = {3'b000, a} << g;
    if (32'(sc) > OUT_MAX) return OUT_W'(OUT_MAX);
    return OUT_W'(sc);
  endfunction

  // Delay visible/line_start so they line up with the synchronised comparator bits
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vis_q <= '0;
      ls_q  <= '0;
    end else begin
      vis_q[0] <= visible;
      ls_q[0]  <= line_start;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        vis_q[k] <= vis_q[k-1];
        ls_q[k]  <= ls_q[k-1];
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    pixel_integrator_chan #(
      .ACC_W      (ACC_W),
      .SYNC_STAGES(SYNC_STAGES),
      .STEP_W     (STEP_W)
    ) u_chan (
      .clock  (clock),
      .reset  (reset),
      .comp_i (comp_in[c]),
      .vis_d_i(vis_d),
      .ls_d_i (ls_d),
      .step_i (step),
      .mode_i (mode),
      .acc_o  (acc_out[c*ACC_W +: ACC_W]),
      .sat_o  (sat_flag[c])
    );
  end

  // Gain-scaled colours during active video, black during blanking
  always_comb begin
    pix_d = '0;
    if (vis_d) begin
      for (int c = 0; c < CHANNELS; c++)
        pix_d[c*OUT_W +: OUT_W] = scale_out(acc_out[c*ACC_W +: ACC_W], gain);
    end
  end

  // Output register stage
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pix_q       <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      pix_q       <= pix_d;
      pix_valid_q <= vis_d;
    end
  end

endmodule

// File: tb/tb_pixel_integrator.sv
// tb/tb_pixel_integrator.sv - randomized self-checking bench for pixel_integrator
module tb_pixel_integrator;

  localparam int S = 2;

  logic        clock;
  logic        reset;
  logic [2:0]  comp_in;
  logic        visible;
  logic        line_start;
  logic [1:0]  step;
  logic [1:0]  mode;
  logic [1:0]  gain;
  logic [23:0] pix_out;
  logic        pix_valid;
  logic [14:0] acc_out;
  logic [2:0]  sat_flag;

  int errs   = 0;
  int checks = 0;

  // Reference state
  int       m_acc[3];
  int       m_pix[3];
  bit       m_sat[3];
  bit       m_pv;
  bit [2:0] q_comp[$];
  bit       q_vis[$];
  bit       q_ls[$];

  pixel_integrator #(
    .CHANNELS(3), .ACC_W(5), .OUT_W(8), .SYNC_STAGES(S), .STEP_W(2)
  ) dut (
    .clock(clock), .reset(reset), .comp_in(comp_in), .visible(visible),
    .line_start(line_start), .step(step), .mode(mode), .gain(gain),
    .pix_out(pix_out), .pix_valid(pix_valid), .acc_out(acc_out), .sat_flag(sat_flag)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_acc[i] = 0; m_pix[i] = 0; m_sat[i] = 0;
    end
    m_pv = 0;
    q_comp.delete(); q_vis.delete(); q_ls.delete();
    for (int k = 0; k < S; k++) begin
      q_comp.push_back(3'b000); q_vis.push_back(1'b0); q_ls.push_back(1'b0);
    end
  endtask

  // One clock edge of the behavioural model, using the inputs present at that edge
  task automatic model_edge();
    bit [2:0] s;
    bit vd, ld;
    int t, p;
    bit clipped;
    if (reset) begin
      model_reset();
      return;
    end
    s  = q_comp.pop_front();
    vd = q_vis.pop_front();
    ld = q_ls.pop_front();
    q_comp.push_back(comp_in);
    q_vis.push_back(visible);
    q_ls.push_back(line_start);
    m_pv = vd;
    for (int i = 0; i < 3; i++) begin
      p = m_acc[i] * (1 << gain);
      m_pix[i] = vd ? ((p > 255) ? 255 : p) : 0;
    end
    for (int i = 0; i < 3; i++) begin
      clipped = 0;
      if (ld && mode == 2'b01) begin
        m_acc[i] = 16;
      end else if (mode != 2'b10 && vd) begin
        t = s[i] ? m_acc[i] + int'(step) : m_acc[i] - int'(step);
        if (t < 0)  begin t = 0;  clipped = 1; end
        if (t > 31) begin t = 31; clipped = 1; end
        m_acc[i] = t;
      end
      if (ld) m_sat[i] = 0;
      else if (clipped) m_sat[i] = 1;
    end
  endtask

  function automatic logic [14:0] exp_acc();
    logic [14:0] e;
    logic [31:0] v;
    e = '0;
    for (int i = 0; i < 3; i++) begin
      v = m_acc[i];
      e[i*5 +: 5] = v[4:0];
    end
    return e;
  endfunction

  task automatic check_all(input string tag);
    logic [23:0] ep;
    logic [2:0]  es;
    logic [31:0] v;
    ep = '0;
    es = '0;
    for (int i = 0; i < 3; i++) begin
      v = m_pix[i];
      ep[i*8 +: 8] = v[7:0];
`ifdef PIXEL_INTEGRATOR_SAT_STATS_EN
      es[i] = m_sat[i];
`endif
    end
    check({tag, ".acc"}, 32'(acc_out), 32'(exp_acc()));
    check({tag, ".pix"}, 32'(pix_out), 32'(ep));
    check({tag, ".valid"}, 32'(pix_valid), 32'(m_pv));
    check({tag, ".sat"}, 32'(sat_flag), 32'(es));
  endtask

  task automatic cycle(input string tag);
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_all(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    check_all("rst");
    reset = 1'b0;
  endtask

  logic [14:0] frozen;

  initial begin
    reset = 1'b1; comp_in = '0; visible = 0; line_start = 0;
    step = 0; mode = 0; gain = 0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    check_all("reset");
    reset = 1'b0;

    // Saturate upward, no wrap
    visible = 1; step = 1; mode = 2'b00; comp_in = 3'b111; gain = 3;
    repeat (40) cycle("up");
    check("sat31_acc", 32'(acc_out), 32'h7fff);
    check("sat31_pix", 32'(pix_out), 32'hf8f8f8);
`ifdef PIXEL_INTEGRATOR_SAT_STATS_EN
    check("sat31_flag", 32'(sat_flag), 32'h7);
`endif

    // Mixed direction, channel 1 must clamp at zero
    do_reset();
    comp_in = 3'b101; step = 2; visible = 1; gain = 0;
    repeat (4) cycle("mix");
    visible = 0;
    repeat (S + 2) cycle("mix");
    check("mix_acc", 32'(acc_out), {17'd0, 5'd8, 5'd0, 5'd8});

    // Line restart to midscale, overriding a concurrent step
    do_reset();
    comp_in = 3'b111; step = 2; visible = 1;
    repeat (S + 10) cycle("ramp");
    check("ramp20", 32'(acc_out), {17'd0, 5'd20, 5'd20, 5'd20});
    mode = 2'b01; line_start = 1;
    cycle("ls");
    line_start = 0;
    repeat (S) cycle("ls");
    check("midscale", 32'(acc_out), {17'd0, 5'd16, 5'd16, 5'd16});

    // Freeze with a toggling comparator, then resume
    mode = 2'b10;
    frozen = exp_acc();
    for (int k = 0; k < 100; k++) begin
      comp_in = 3'($urandom);
      cycle("frz");
    end
    check("freeze", 32'(acc_out), 32'(frozen));
    mode = 2'b00; comp_in = 3'b000;
    repeat (3) cycle("resume");

    // Blanking
    visible = 0;
    repeat (S + 2) cycle("blank");
    check("blank_valid", 32'(pix_valid), 32'd0);
    check("blank_pix", 32'(pix_out), 32'd0);

    // Asynchronous reset mid-line
    do_reset();
    comp_in = 3'b111; step = 1; visible = 1; gain = 1;
    repeat (S + 25) cycle("to25");
    check("acc25", 32'(acc_out), {17'd0, 5'd25, 5'd25, 5'd25});
    @(posedge clock);
    model_edge();
    #2 reset = 1'b1;
    #1;
    check("arst_acc", 32'(acc_out), 32'd0);
    check("arst_pix", 32'(pix_out), 32'd0);
    check("arst_valid", 32'(pix_valid), 32'd0);
    check("arst_sat", 32'(sat_flag), 32'd0);
    model_reset();
    @(negedge clock);
    check_all("arst");
    reset = 1'b0;

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      comp_in    = 3'($urandom);
      visible    = ($urandom_range(0, 7) != 0);
      line_start = ($urandom_range(0, 15) == 0);
      step       = 2'($urandom);
      mode       = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      gain       = 2'($urandom);
      cycle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/pixel_integrator.md
Name: pixel_integrator

Overview:
Parametrised per-channel saturating up/down integrator that reconstructs pixel intensity from 1-bit comparator streams (GPIO analog-capture path) during the visible VGA window. Successor of the fixed 3x5-bit integrator. Adds configurable channel count and widths, step size, per-line restart mode, gain-scaled output with saturation, and a valid strobe. Sits between the GPIO comparator inputs and the VGA colour-output register stage, clocked by the pixel PLL clock.

Parameters:
CHANNELS, 3, number of comparator/colour channels
ACC_W, 5, accumulator width per channel
OUT_W, 8, output colour width per channel
SYNC_STAGES, 2, synchroniser flops on comp_in (min 1)
STEP_W, 2, width of step input

Ports:
clock  input  1  pixel clock
reset  input  1  asynchronous, active-high
comp_in  input  CHANNELS  raw comparator bits, asynchronous to clock; bit i drives channel i
visible  input  1  active-video qualifier from VGA controller
line_start  input  1  one-cycle pulse at the first cycle of each line
step  input  STEP_W  increment/decrement magnitude; 0 = no change
mode  input  2  00 free-run, 01 restart-per-line, 10 freeze, 11 = free-run
gain  input  2  left-shift 0..3 applied to accumulator for output
pix_out  output  CHANNELS*OUT_W  scaled colours; channel i at [i*OUT_W +: OUT_W]
pix_valid  output  1  pix_out is active video
acc_out  output  CHANNELS*ACC_W  raw accumulators (debug/LEDs)
sat_flag  output  CHANNELS  sticky saturation flags (see Optional Feature)

Behaviour:
- Reset: all accumulators, synchroniser flops, pix_out, pix_valid and sat_flag go to 0 immediately. Reset has priority over every other event.
- comp_in passes through SYNC_STAGES flops. Synchronised bit s[i] is used in the update.
- The visible input is delayed by SYNC_STAGES so it stays aligned with s. Call the delayed signal vis_d. line_start is delayed by the same amount (ls_d).
- Per-channel update, each cycle, in priority order:
  - ls_d=1 and mode=01: acc loaded with midscale 2^(ACC_W-1).
  - mode=10: acc holds.
  - vis_d=1: s[i]=1 gives acc+step; s[i]=0 gives acc-step.
  - Otherwise acc holds.
- Arithmetic is done in ACC_W+1 bits and clamped to [0, 2^ACC_W-1]. No wrap-around ever occurs.
- Latency: comp_in edge to acc change = SYNC_STAGES+1 cycles. acc to pix_out = 1 cycle.
- Output register:
  - If vis_d is high in a cycle, on the next edge pix_valid=1.
  - pix_out[i] = min(acc[i] << gain, 2^OUT_W-1), computed in ACC_W+3 bits before the clamp.
  - Otherwise pix_valid=0 and pix_out=0 (blanking).
- Changes to mode, gain and step take effect on the next clock edge, including mid-line. No glitch handling beyond that.
- acc_out is the accumulator register itself (zero latency).
- Reset asserted mid-line: outputs are 0 until the first post-reset vis_d.

Optional Feature:
PIXEL_INTEGRATOR_SAT_STATS_EN:
- Defined: sat_flag[i] is set, sticky, in the cycle an update of channel i is clamped at 0 or at full scale. sat_flag is cleared by ls_d, with clear priority over set in the same cycle.
- Undefined: sat_flag is tied to 0 and no related logic is generated.

Decomposition:
- Package pixel_integrator_pkg:
  - mode encodings MODE_FREE=2'b00, MODE_LINE=2'b01, MODE_FREEZE=2'b10
  - midscale and saturating-add helper functions parametrised by width
- Sub-module pixel_integrator_chan: one synchronised accumulator plus clamp plus sat flag. Generate-instantiated CHANNELS times.
- The top level holds the delay of visible/line_start and the gain/output register.

Test Plan:
- Reset, then visible=1, step=1, mode=00, comp_in all 1 for 40 cycles -> acc_out saturates at 31 on every channel and does not wrap; pix_out with gain=3 is 248 (31<<3). With the macro defined, sat_flag=3'b111.
- comp_in=3'b101 with step=2 for 4 active cycles after reset -> acc = {8,0,8}. Channel 1 stays at 0 without underflow.
- mode=01, acc=20, line_start pulse -> SYNC_STAGES cycles later acc=16 on all channels. A simultaneous update is ignored in that cycle.
- mode=10 with toggling comp_in for 100 cycles -> acc unchanged. Switching back to 00 resumes integration the next cycle.
- visible=0 -> pix_valid=0 and pix_out=0 one cycle after vis_d falls, while acc holds.
- Asserting reset asynchronously mid-line with acc=25 -> all outputs are 0 before the next clock edge.
